// File: rtl/ps2_grid_cursor.sv
// PS/2 key events -> cursor position on a COLS x ROWS grid, with one-cycle action pulses.
// Latency: a new key event in cycle N updates cursor and pulses at the edge that ends N.
// Backpressure: none; events are sampled every cycle and enable=0 freezes the cursor.
//
// Ports:
//   clk, rstn     clock; asynchronous active-low reset
//   key_event     level-held decoder word: [10] valid, [9] E0-extended, [8] break, [7:0] scan code
//   enable        1 accepts keys; 0 drops the held key, freezes the cursor, suppresses pulses
//   cursor_x/y    current cell, always < COLS / < ROWS
//   select_pulse  Space make; promo_pulse G make; cancel_pulse Esc make
//   moved_pulse   cursor value changed at the last edge
module ps2_grid_cursor #(
  parameter int COLS         = 8,
  parameter int ROWS         = 8,
  parameter int XW           = 3,
  parameter int YW           = 3,
  parameter int WRAP         = 1,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [10:0]   key_event,
  input  logic          enable,
  output logic [XW-1:0] cursor_x,
  output logic [YW-1:0] cursor_y,
  output logic          select_pulse,
  output logic          promo_pulse,
  output logic          cancel_pulse,
  output logic          moved_pulse
);

  // Counter holds values up to max(delay, rate) - 1.
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  // Direction vector bits: {up, down, left, right}.
  function automatic logic [3:0] dir_of(input logic [7:0] code, input logic ext);
    dir_of = 4'b0000;
    case (code)
      // Arrow/keypad codes work with or without the E0 prefix.
      8'h75: dir_of = 4'b1000;
      8'h72: dir_of = 4'b0100;
      8'h6B: dir_of = 4'b0010;
      8'h74: dir_of = 4'b0001;
      default: begin
        if (!ext) begin
          case (code)
            8'h1D:        dir_of = 4'b1000;  // W
            8'h1B, 8'h22: dir_of = 4'b0100;  // S, X
            8'h1C:        dir_of = 4'b0010;  // A
            8'h23:        dir_of = 4'b0001;  // D
            8'h15:        dir_of = 4'b1010;  // Q up-left
            8'h24:        dir_of = 4'b1001;  // E up-right
            8'h1A:        dir_of = 4'b0110;  // Z down-left
            8'h21:        dir_of = 4'b0101;  // C down-right
            default:      dir_of = 4'b0000;
          endcase
        end
      end
    endcase
  endfunction

  // One axis step, computed one bit wider so max+1 is representable before wrap/clamp.
  function automatic logic [XW-1:0] step_x(input logic [XW-1:0] v, input logic dec, input logic inc);
    logic [XW:0] w;
    w      = {1'b0, v};
    step_x = v;
    if (inc) begin
      w = w + (XW+1)'(1);
      if (w >= (XW+1)'(COLS)) step_x = (WRAP != 0) ? '0 : v;
      else                    step_x = w[XW-1:0];
    end else if (dec) begin
      if (w == '0) step_x = (WRAP != 0) ? XW'(COLS-1) : v;
      else begin
        w      = w - (XW+1)'(1);
        step_x = w[XW-1:0];
      end
    end
  endfunction

  function automatic logic [YW-1:0] step_y(input logic [YW-1:0] v, input logic dec, input logic inc);
    logic [YW:0] w;
    w      = {1'b0, v};
    step_y = v;
    if (inc) begin
      w = w + (YW+1)'(1);
      if (w >= (YW+1)'(ROWS)) step_y = (WRAP != 0) ? '0 : v;
      else                    step_y = w[YW-1:0];
    end else if (dec) begin
      if (w == '0) step_y = (WRAP != 0) ? YW'(ROWS-1) : v;
      else begin
        w      = w - (YW+1)'(1);
        step_y = w[YW-1:0];
      end
    end
  endfunction

  state_t        state_q;
  logic [10:0]   prev_evt_q;
  logic [7:0]    held_code_q;
  logic [3:0]    held_dir_q;
  logic [CW-1:0] cnt_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          sel_q, promo_q, cancel_q, moved_q;

  logic          evt_new, evt_brk, evt_ext;
  logic [7:0]    evt_code;
  logic [3:0]    evt_dir, mv_dir;
  logic          dir_make, held_brk, rpt_fire;
  logic          sel_d, promo_d, cancel_d;
  logic [XW-1:0] x_d;
  logic [YW-1:0] y_d;

  always_comb begin
    // Typematic re-sends are identical words, so only a change counts as an event.
    evt_new  = key_event[10] && (key_event != prev_evt_q);
    evt_ext  = key_event[9];
    evt_brk  = key_event[8];
    evt_code = key_event[7:0];
    evt_dir  = dir_of(evt_code, evt_ext);

    // A fresh make of the key already held is not a new press; the timer keeps running.
    dir_make = enable && evt_new && !evt_brk && (evt_dir != 4'b0000) &&
               ((state_q == IDLE) || (evt_code != held_code_q));
    held_brk = enable && evt_new && evt_brk && (state_q != IDLE) && (evt_code == held_code_q);
    // An event that moves or releases wins over the timer, so one move per cycle at most.
    rpt_fire = enable && (state_q != IDLE) && (cnt_q == '0) && (REPEAT_RATE != 0) &&
               !dir_make && !held_brk;

    mv_dir = dir_make ? evt_dir : (rpt_fire ? held_dir_q : 4'b0000);
    x_d    = step_x(x_q, mv_dir[1], mv_dir[0]);
    y_d    = step_y(y_q, mv_dir[3], mv_dir[2]);

    sel_d    = enable && evt_new && !evt_brk && !evt_ext && (evt_code == 8'h29);
    promo_d  = enable && evt_new && !evt_brk && !evt_ext && (evt_code == 8'h34);
    cancel_d = enable && evt_new && !evt_brk && !evt_ext && (evt_code == 8'h76);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      prev_evt_q  <= '0;
      held_code_q <= '0;
      held_dir_q  <= '0;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      sel_q       <= 1'b0;
      promo_q     <= 1'b0;
      cancel_q    <= 1'b0;
      moved_q     <= 1'b0;
    end else begin
      prev_evt_q <= key_event;
      x_q        <= x_d;
      y_q        <= y_d;
      moved_q    <= (x_d != x_q) || (y_d != y_q);
      sel_q      <= sel_d;
      promo_q    <= promo_d;
      cancel_q   <= cancel_d;

      if (!enable) begin
        state_q     <= IDLE;
        cnt_q       <= '0;
        held_code_q <= '0;
        held_dir_q  <= '0;
      end else if (dir_make) begin
        held_code_q <= evt_code;
        held_dir_q  <= evt_dir;
        cnt_q       <= CW'(REPEAT_DELAY - 1);
        state_q     <= DELAY;
      end else if (held_brk) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: ;
          DELAY: begin
            if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
            else if (REPEAT_RATE != 0) begin
              cnt_q   <= CW'(REPEAT_RATE - 1);
              state_q <= REPEAT;
            end
            // With auto-repeat disabled the counter parks at zero until release.
          end
          REPEAT: begin
            if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
            else             cnt_q <= CW'(REPEAT_RATE - 1);
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign cursor_x     = x_q;
  assign cursor_y     = y_q;
  assign select_pulse = sel_q;
  assign promo_pulse  = promo_q;
  assign cancel_pulse = cancel_q;
  assign moved_pulse  = moved_q;

endmodule

// File: tb/tb_ps2_grid_cursor.sv
module tb_ps2_grid_cursor;

  localparam int DLY  = 20;
  localparam int RATE = 5;
  localparam int N    = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic [10:0] key_event;
  logic        enable;

  logic [2:0] x0, y0, x1, y1;
  logic       sel0, pro0, can0, mv0, sel1, pro1, can1, mv1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ps2_grid_cursor #(.COLS(8), .ROWS(8), .XW(3), .YW(3), .WRAP(1),
                    .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)) dut_wrap (
    .clk(clk), .rstn(rstn), .key_event(key_event), .enable(enable),
    .cursor_x(x0), .cursor_y(y0), .select_pulse(sel0), .promo_pulse(pro0),
    .cancel_pulse(can0), .moved_pulse(mv0));

  ps2_grid_cursor #(.COLS(8), .ROWS(8), .XW(3), .YW(3), .WRAP(0),
                    .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)) dut_sat (
    .clk(clk), .rstn(rstn), .key_event(key_event), .enable(enable),
    .cursor_x(x1), .cursor_y(y1), .select_pulse(sel1), .promo_pulse(pro1),
    .cancel_pulse(can1), .moved_pulse(mv1));

  // Reference model: cursor per instance (0 = wrap, 1 = saturate), held key and its age in cycles.
  logic [10:0] m_prev;
  int          mx[2], my[2];
  bit          e_mv[2];
  bit          e_sel, e_pro, e_can;
  bit          m_held_v;
  logic [7:0]  m_held;
  int          m_hdx, m_hdy, m_age;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("x_wrap",      {29'd0, x0}, mx[0]);
    check("y_wrap",      {29'd0, y0}, my[0]);
    check("moved_wrap",  {31'd0, mv0}, {31'd0, e_mv[0]});
    check("select_wrap", {31'd0, sel0}, {31'd0, e_sel});
    check("promo_wrap",  {31'd0, pro0}, {31'd0, e_pro});
    check("cancel_wrap", {31'd0, can0}, {31'd0, e_can});
    check("x_sat",       {29'd0, x1}, mx[1]);
    check("y_sat",       {29'd0, y1}, my[1]);
    check("moved_sat",   {31'd0, mv1}, {31'd0, e_mv[1]});
    check("select_sat",  {31'd0, sel1}, {31'd0, e_sel});
    check("promo_sat",   {31'd0, pro1}, {31'd0, e_pro});
    check("cancel_sat",  {31'd0, can1}, {31'd0, e_can});
  endtask

  task automatic model_reset();
    m_prev = '0;
    mx[0] = 0; my[0] = 0; mx[1] = 0; my[1] = 0;
    e_mv[0] = 0; e_mv[1] = 0;
    e_sel = 0; e_pro = 0; e_can = 0;
    m_held_v = 0; m_held = '0; m_hdx = 0; m_hdy = 0; m_age = 0;
  endtask

  // Key table: (dx, dy) with y growing downward; letters only without the E0 prefix.
  task automatic dir_lookup(input logic [7:0] code, input logic ext, output bit is_dir,
                            output int dx, output int dy);
    is_dir = 1; dx = 0; dy = 0;
    if      (code == 8'h75) dy = -1;
    else if (code == 8'h72) dy = 1;
    else if (code == 8'h6B) dx = -1;
    else if (code == 8'h74) dx = 1;
    else if (ext) is_dir = 0;
    else if (code == 8'h1D) dy = -1;
    else if (code == 8'h1B || code == 8'h22) dy = 1;
    else if (code == 8'h1C) dx = -1;
    else if (code == 8'h23) dx = 1;
    else if (code == 8'h15) begin dx = -1; dy = -1; end
    else if (code == 8'h24) begin dx = 1;  dy = -1; end
    else if (code == 8'h1A) begin dx = -1; dy = 1;  end
    else if (code == 8'h21) begin dx = 1;  dy = 1;  end
    else is_dir = 0;
  endtask

  task automatic model_move(input int dx, input int dy);
    int nx, ny;
    nx = (mx[0] + dx + N) % N;
    ny = (my[0] + dy + N) % N;
    e_mv[0] = (nx != mx[0]) || (ny != my[0]);
    mx[0] = nx; my[0] = ny;
    nx = mx[1] + dx; if (nx < 0) nx = 0; if (nx > N-1) nx = N-1;
    ny = my[1] + dy; if (ny < 0) ny = 0; if (ny > N-1) ny = N-1;
    e_mv[1] = (nx != mx[1]) || (ny != my[1]);
    mx[1] = nx; my[1] = ny;
  endtask

  task automatic model_edge(input logic [10:0] k, input logic en);
    bit nw, is_dir, brk;
    int dx, dy;
    nw  = k[10] && (k != m_prev);
    brk = k[8];
    m_prev = k;
    e_sel = 0; e_pro = 0; e_can = 0;
    e_mv[0] = 0; e_mv[1] = 0;
    if (!en) begin
      m_held_v = 0;
      return;
    end
    if (nw && !brk && !k[9]) begin
      e_sel = (k[7:0] == 8'h29);
      e_pro = (k[7:0] == 8'h34);
      e_can = (k[7:0] == 8'h76);
    end
    dir_lookup(k[7:0], k[9], is_dir, dx, dy);
    if (nw && !brk && is_dir && !(m_held_v && k[7:0] == m_held)) begin
      m_held_v = 1; m_held = k[7:0]; m_hdx = dx; m_hdy = dy; m_age = 0;
      model_move(dx, dy);
    end else if (nw && brk && m_held_v && k[7:0] == m_held) begin
      m_held_v = 0;
    end else if (m_held_v) begin
      m_age++;
      if (m_age >= DLY && (m_age - DLY) % RATE == 0) model_move(m_hdx, m_hdy);
    end
  endtask

  // One clock: drive, let the edge happen, advance the model, compare 1 time unit later.
  task automatic cyc(input logic [10:0] k, input logic en);
    key_event = k;
    enable    = en;
    @(posedge clk);
    model_edge(k, en);
    #1;
    check_all();
  endtask

  task automatic hold(input int n, input logic [10:0] k, input logic en);
    for (int i = 0; i < n; i++) cyc(k, en);
  endtask

  logic [7:0] codes[18] = '{8'h1D, 8'h75, 8'h1B, 8'h22, 8'h72, 8'h1C, 8'h6B, 8'h23, 8'h74,
                            8'h15, 8'h24, 8'h1A, 8'h21, 8'h29, 8'h34, 8'h76, 8'h11, 8'h5A};

  initial begin
    logic [10:0] k;
    logic [7:0]  c;
    logic        en;
    rstn = 1'b0; key_event = '0; enable = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_x", {29'd0, x0}, 32'd0);
    check("reset_y", {29'd0, y0}, 32'd0);
    check("reset_pulses", {28'd0, sel0, pro0, can0, mv0}, 32'd0);
    check_all();
    rstn = 1'b1;

    // D make: one step right, then no typematic moves inside the delay window.
    cyc(11'h423, 1);
    check("d_make_x", {29'd0, x0}, 32'd1);
    check("d_make_moved", {31'd0, mv0}, 32'd1);
    hold(10, 11'h423, 1);
    check("d_hold_x", {29'd0, x0}, 32'd1);
    cyc(11'h523, 1);

    // Left from x=0: wraps on one instance, clamps silently on the other.
    cyc(11'h41C, 1); cyc(11'h51C, 1);
    cyc(11'h41C, 1);
    check("a_wrap_x", {29'd0, x0}, 32'd7);
    check("a_sat_x", {29'd0, x1}, 32'd0);
    check("a_sat_moved", {31'd0, mv1}, 32'd0);
    cyc(11'h51C, 1);

    // Held W from y=7: move on make, then repeats 20, 25, 30 cycles later.
    cyc(11'h41D, 1); cyc(11'h51D, 1);
    cyc(11'h41D, 1);
    check("w_make_y", {29'd0, y0}, 32'd6);
    hold(20, 11'h41D, 1);
    check("w_rep1_y", {29'd0, y0}, 32'd5);
    hold(5, 11'h41D, 1);
    check("w_rep2_y", {29'd0, y0}, 32'd4);
    hold(5, 11'h41D, 1);
    check("w_rep3_y", {29'd0, y0}, 32'd3);
    cyc(11'h51D, 1);
    hold(10, 11'h51D, 1);
    check("w_release_y", {29'd0, y0}, 32'd3);

    // Action keys.
    cyc(11'h429, 1);
    check("space_select", {31'd0, sel0}, 32'd1);
    cyc(11'h429, 1);
    check("space_one_cycle", {31'd0, sel0}, 32'd0);
    cyc(11'h434, 1);
    check("g_promo", {31'd0, pro0}, 32'd1);
    cyc(11'h476, 1);
    check("esc_cancel", {31'd0, can0}, 32'd1);
    cyc(11'h000, 1);

    // Second direction while D is in its delay: S takes over and restarts the timer.
    cyc(11'h423, 1);
    hold(5, 11'h423, 1);
    cyc(11'h41B, 1);
    hold(30, 11'h41B, 1);
    check("s_takeover_y", {29'd0, y0}, 32'd7);
    check("s_takeover_x", {29'd0, x0}, 32'd0);
    cyc(11'h51B, 1);

    // Held C, enable dropped after the first repeat, then async reset mid-repeat.
    cyc(11'h421, 1);
    hold(21, 11'h421, 1);
    hold(10, 11'h421, 0);
    check("c_frozen_x", {29'd0, x0}, 32'd2);
    hold(10, 11'h421, 1);
    check("c_reenable_x", {29'd0, x0}, 32'd2);
    cyc(11'h424, 1);
    hold(23, 11'h424, 1);
    rstn = 1'b0;
    #1;
    model_reset();
    check("rst_mid_x", {29'd0, x0}, 32'd0);
    check("rst_mid_y", {29'd0, y0}, 32'd0);
    check("rst_mid_pulses", {28'd0, sel0, pro0, can0, mv0}, 32'd0);
    check_all();
    @(negedge clk);
    rstn = 1'b1;
    cyc(11'h000, 1);

    // Random key traffic with long holds so auto-repeat engages.
    k  = 11'h000;
    en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        c = codes[$urandom_range(0, 17)];
        k[7:0] = c;
        k[9]   = (c == 8'h75 || c == 8'h72 || c == 8'h6B || c == 8'h74) ? 1'($urandom_range(0, 1)) : 1'b0;
        k[8]   = ($urandom_range(0, 2) == 0);
        k[10]  = ($urandom_range(0, 9) != 0);
      end
      if ($urandom_range(0, 39) == 0) en = ~en;
      else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
      cyc(k, en);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
